uart_tx_cfg: RTL and testbench

UART transmitter with runtime-configurable framing and an internal transmit FIFO.
- Framing: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Sits between the peripheral register interface and the uart_txd pad.
- The bus side pushes bytes into the FIFO; the serialiser drains frames back-to-back with no idle gap.

---
 rtl/uart_tx_cfg.sv | 205 ++++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime framing (5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits) fed by a small transmit FIFO; queued frames go out back-to-back.
module uart_tx_cfg #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16,
    localparam int LVL_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic [1:0]           data_bits,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    output logic                 wr_ready,
    output logic [LVL_WIDTH-1:0] fifo_level,
    output logic                 overflow,
    output logic                 uart_txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;

    state_t               state, state_n;
    logic [DIV_WIDTH-1:0] cnt, cnt_n;
    logic [3:0]           bit_cnt, bit_cnt_n;
    logic [7:0]           shreg, shreg_n;
    logic                 par, par_n;
    logic                 stop_idx, stop_idx_n;
    logic [DIV_WIDTH-1:0] div_l, div_l_n;
    logic [1:0]           bits_l, bits_l_n;
    logic [1:0]           pmode_l, pmode_l_n;
    logic                 stop_l, stop_l_n;
    logic                 txd_n;

    logic                 bit_end;
    logic                 last_bit;
    logic                 par_en;
    logic                 frame_end;
    logic                 load;

    // Full/empty come from the registered level, so a same-cycle pop never admits a write when full.
    assign fifo_full  = (fifo_level == LVL_WIDTH'(FIFO_DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign wr_ready   = ~fifo_full;
    assign push       = wr_en & ~fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            overflow <= wr_en & fifo_full;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_WIDTH'(1);
                2'b01:   fifo_level <= fifo_level - LVL_WIDTH'(1);
                default: ;
            endcase
        end
    end

    assign bit_end   = (cnt == div_l);
    assign last_bit  = (bit_cnt == ({2'b00, bits_l} + 4'd4));
    assign par_en    = (pmode_l == 2'b01) || (pmode_l == 2'b10);
    assign frame_end = (state == STOP) && bit_end && (stop_idx == stop_l);
    assign load      = ~fifo_empty && ((state == IDLE) || frame_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par      <= 1'b0;
            stop_idx <= 1'b0;
            div_l    <= '0;
            bits_l   <= '0;
            pmode_l  <= '0;
            stop_l   <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            par      <= par_n;
            stop_idx <= stop_idx_n;
            div_l    <= div_l_n;
            bits_l   <= bits_l_n;
            pmode_l  <= pmode_l_n;
            stop_l   <= stop_l_n;
            uart_txd <= txd_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_n      = par;
        stop_idx_n = stop_idx;
        div_l_n    = div_l;
        bits_l_n   = bits_l;
        pmode_l_n  = pmode_l;
        stop_l_n   = stop_l;
        pop        = 1'b0;
        case (state)
            IDLE: ;
            START: begin
                cnt_n = cnt + DIV_WIDTH'(1);
                if (bit_end) begin
                    cnt_n     = '0;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                cnt_n = cnt + DIV_WIDTH'(1);
                if (bit_end) begin
                    cnt_n     = '0;
                    shreg_n   = shreg >> 1;
                    par_n     = par ^ shreg[0];
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (last_bit) begin
                        stop_idx_n = 1'b0;
                        state_n    = par_en ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                cnt_n = cnt + DIV_WIDTH'(1);
                if (bit_end) begin
                    cnt_n      = '0;
                    stop_idx_n = 1'b0;
                    state_n    = STOP;
                end
            end
            STOP: begin
                cnt_n = cnt + DIV_WIDTH'(1);
                if (bit_end) begin
                    cnt_n = '0;
                    if (stop_idx == stop_l) begin
                        state_n = IDLE;
                    end else begin
                        stop_idx_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Framing is captured per frame so config changes only affect later frames.
        if (load) begin
            pop       = 1'b1;
            shreg_n   = fifo_mem[rd_ptr];
            div_l_n   = divider;
            bits_l_n  = data_bits;
            pmode_l_n = parity_mode;
            stop_l_n  = stop_bits;
            par_n     = 1'b0;
            cnt_n     = '0;
            state_n   = START;
        end
    end

    // The pad value is computed from the next state so the register leads the FSM by nothing.
    always_comb begin
        txd_n = 1'b1;
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shreg_n[0];
            PARITY:  txd_n = par_n ^ (pmode_l_n == 2'b10);
            default: txd_n = 1'b1;
        endcase
        tx_done = frame_end;
        tx_busy = (state != IDLE) || ~fifo_empty;
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a serial monitor decodes every frame on uart_txd and
// compares it with the frame queued when the byte was written.
module tb_uart_tx_cfg;

    localparam int FIFO_DEPTH = 4;
    localparam int DIV_WIDTH  = 16;
    localparam int LVL_WIDTH  = $clog2(FIFO_DEPTH + 1);

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         pmode;
        int         nstop;
        int         div;
    } frame_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [DIV_WIDTH-1:0] divider = 16'd9;
    logic [1:0]           data_bits = 2'b11;
    logic [1:0]           parity_mode = 2'b00;
    logic                 stop_bits = 1'b0;
    logic                 wr_en = 1'b0;
    logic [7:0]           wr_data = 8'h00;
    logic                 wr_ready;
    logic [LVL_WIDTH-1:0] fifo_level;
    logic                 overflow;
    logic                 uart_txd;
    logic                 tx_busy;
    logic                 tx_done;

    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    int     wr_cyc = 0;
    frame_t exp_q[$];

    frame_t cur;
    bit     mon_active = 1'b0;
    int     mon_pos = 0;
    int     frames_done = 0;
    int     done_pulses = 0;
    int     done_cyc = 0;
    int     last_start = 0;
    int     last_end = 0;
    bit     check_gap = 1'b0;
    int     gap_ref = 0;

    uart_tx_cfg #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .divider     (divider),
        .data_bits   (data_bits),
        .parity_mode (parity_mode),
        .stop_bits   (stop_bits),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .uart_txd    (uart_txd),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic int frameBits(input frame_t f);
        return 1 + f.nbits + (((f.pmode == 1) || (f.pmode == 2)) ? 1 : 0) + f.nstop;
    endfunction

    function automatic logic expBit(input frame_t f, input int idx);
        logic [7:0] d;
        logic       p;
        d = f.data;
        if (idx == 0) return 1'b0;
        if (idx <= f.nbits) return d[idx-1];
        if (((f.pmode == 1) || (f.pmode == 2)) && (idx == f.nbits + 1)) begin
            p = 1'b0;
            for (int i = 0; i < f.nbits; i++) p = p ^ d[i];
            return (f.pmode == 2) ? ~p : p;
        end
        return 1'b1;
    endfunction

    // Serial monitor: sample each bit mid-period and expect tx_done only in a frame's last cycle.
    always @(negedge clk) begin
        int period;
        int total;
        int idx;
        int phase;
        if (tx_done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc;
        end
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && uart_txd === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_start", 32'(uart_txd), 32'd1);
                end else begin
                    cur        = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_pos    = 0;
                    last_start = cyc;
                    if (check_gap && frames_done > gap_ref)
                        checkOutput("frame_gap", cyc - last_end, 32'd1);
                end
            end
            if (mon_active) begin
                period = cur.div + 1;
                total  = frameBits(cur) * period;
                idx    = mon_pos / period;
                phase  = mon_pos % period;
                if (phase == period / 2)
                    checkOutput("txd_bit", 32'(uart_txd), 32'(expBit(cur, idx)));
                if (mon_pos == total - 1) begin
                    checkOutput("tx_done_end", 32'(tx_done), 32'd1);
                    last_end    = cyc;
                    frames_done = frames_done + 1;
                    mon_active  = 1'b0;
                end else if (phase == period - 1) begin
                    checkOutput("tx_done_early", 32'(tx_done), 32'd0);
                end
                mon_pos++;
            end
        end
    end

    task automatic setCfg(input int dv, input int nb, input int pm, input int ns);
        divider     = DIV_WIDTH'(dv);
        data_bits   = 2'(nb - 5);
        parity_mode = 2'(pm);
        stop_bits   = 1'(ns - 1);
    endtask

    // Drives one write cycle; the frame it should produce is queued when accepted.
    task automatic applyStimulus(input logic [7:0] d, input int nb, input int pm, input int ns,
                                 input int dv, input bit accept);
        frame_t f;
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_data = d;
        wr_cyc  = cyc;
        if (accept) begin
            f.data  = d;
            f.nbits = nb;
            f.pmode = pm;
            f.nstop = ns;
            f.div   = dv;
            exp_q.push_back(f);
        end
    endtask

    task automatic idleBus();
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frames_sent", frames_done, target);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wr0;
        int base;
        int dp0;
        int low;
        int n;
        logic [7:0] bytes [5];
        bytes = '{8'h11, 8'hC3, 8'h7E, 8'h80, 8'h01};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_txd", 32'(uart_txd), 32'd1);
        checkOutput("rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("rst_ready", 32'(wr_ready), 32'd1);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_done", 32'(tx_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 8N1, divider 9, exact latency and completion timing
        setCfg(9, 8, 0, 1);
        applyStimulus(8'hA5, 8, 0, 1, 9, 1'b1);
        wr0 = wr_cyc;
        idleBus();
        while (cyc < wr0 + 101) @(negedge clk);
        checkOutput("busy_at_101", 32'(tx_busy), 32'd1);
        checkOutput("done_at_101", 32'(tx_done), 32'd1);
        @(negedge clk);
        checkOutput("busy_at_102", 32'(tx_busy), 32'd0);
        checkOutput("done_at_102", 32'(tx_done), 32'd0);
        checkOutput("start_latency", last_start - wr0, 32'd2);
        checkOutput("done_cycle", done_cyc - wr0, 32'd101);
        waitFrames(1, 10);

        // 7E2, divider 9
        setCfg(9, 7, 1, 2);
        base = frames_done;
        applyStimulus(8'hB5, 7, 1, 2, 9, 1'b1);
        idleBus();
        waitFrames(base + 1, 300);
        checkOutput("len_7E2", done_cyc - last_start + 1, 32'd110);

        // 5O1, divider 3
        setCfg(3, 5, 2, 1);
        base = frames_done;
        applyStimulus(8'h1F, 5, 2, 1, 3, 1'b1);
        idleBus();
        waitFrames(base + 1, 100);
        checkOutput("len_5O1", done_cyc - last_start + 1, 32'd32);

        // FIFO fill, overflow and back-to-back frames
        setCfg(1, 8, 0, 1);
        base      = frames_done;
        dp0       = done_pulses;
        gap_ref   = base;
        check_gap = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(bytes[i], 8, 0, 1, 1, 1'b1);
        applyStimulus(8'hEE, 8, 0, 1, 1, 1'b0);
        @(negedge clk);
        checkOutput("full_level", 32'(fifo_level), 32'd4);
        checkOutput("full_ready", 32'(wr_ready), 32'd0);
        checkOutput("ovf_not_yet", 32'(overflow), 32'd0);
        idleBus();
        @(negedge clk);
        checkOutput("ovf_pulse", 32'(overflow), 32'd1);
        checkOutput("ovf_level", 32'(fifo_level), 32'd4);
        @(negedge clk);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);
        waitFrames(base + 5, 400);
        checkOutput("done_pulses", done_pulses - dp0, 32'd5);
        check_gap = 1'b0;

        // Config change mid-frame: queued frame picks up the new framing
        setCfg(3, 8, 0, 1);
        base      = frames_done;
        gap_ref   = base;
        check_gap = 1'b1;
        applyStimulus(8'h3C, 8, 0, 1, 3, 1'b1);
        applyStimulus(8'h5A, 5, 1, 1, 3, 1'b1);
        idleBus();
        n = 0;
        while (!mon_active && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        setCfg(3, 5, 1, 1);
        waitFrames(base + 2, 200);
        checkOutput("len_5E1", done_cyc - last_start + 1, 32'd32);
        check_gap = 1'b0;

        // Reset during DATA of frame 2 with two entries still queued
        setCfg(3, 8, 0, 1);
        base = frames_done;
        for (int i = 0; i < 4; i++) applyStimulus(bytes[i], 8, 0, 1, 3, 1'b1);
        idleBus();
        n = 0;
        while (!(frames_done == base + 1 && mon_active && mon_pos >= 6) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_frame2", frames_done, base + 1);
        checkOutput("queued_before_rst", 32'(fifo_level), 32'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_txd", 32'(uart_txd), 32'd1);
        checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
        checkOutput("mid_rst_busy", 32'(tx_busy), 32'd0);
        checkOutput("mid_rst_ready", 32'(wr_ready), 32'd1);
        dp0  = done_pulses;
        base = frames_done;
        low  = 0;
        repeat (100) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) low++;
        end
        checkOutput("post_rst_low", low, 32'd0);
        checkOutput("post_rst_done", done_pulses - dp0, 32'd0);
        checkOutput("post_rst_frames", frames_done - base, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
